// File: rtl/sprite_position_regfile_if.sv
// CPU data-memory port of the sprite position register file.
// Active-low write strobe, byte address, write data in, combinational read data out.
interface sprite_position_regfile_if;
    logic        memWr;
    logic [31:0] address;
    logic [31:0] datoIn;
    logic [31:0] datoOut;

    modport master (output memWr, output address, output datoIn, input datoOut);
    modport slave  (input memWr, input address, input datoIn, output datoOut);
endinterface

// File: rtl/sprite_position_regfile.sv
// Double-buffered X/Y/VEL/CTRL register file for N actors with a per-frame move engine.
// Latency: writes land on the same falling edge; sprite i's display updates at tick edge + 1 + i; no backpressure.
module sprite_position_regfile #(
    parameter int          N_SPRITES = 5,
    parameter int          COORD_W   = 10,
    parameter int          SCREEN_W  = 640,
    parameter int          SCREEN_H  = 480,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic                           clk,
    input  logic                           reset,
    sprite_position_regfile_if.slave       bus,
    input  logic                           frameTick,
    output logic [N_SPRITES*COORD_W-1:0]   spriteX,
    output logic [N_SPRITES*COORD_W-1:0]   spriteY,
    output logic [N_SPRITES-1:0]           spriteEn
);
    localparam int IW   = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;
    localparam int SIGW = COORD_W + 2;
    localparam logic signed [SIGW-1:0] LIM_X = SIGW'(SCREEN_W);
    localparam logic signed [SIGW-1:0] LIM_Y = SIGW'(SCREEN_H);

    typedef enum logic {IDLE, UPDATE} state_t;

    state_t             state;
    logic [IW-1:0]      idx;
    logic [COORD_W-1:0] sh_x [N_SPRITES];
    logic [COORD_W-1:0] sh_y [N_SPRITES];
    logic [15:0]        vel  [N_SPRITES];
    logic [2:0]         ctrl [N_SPRITES];
    logic [15:0]        frame_count;
    logic               overrun;

    logic [31:0]        off;
    logic [29:0]        widx;
    logic               wr_en;
    logic               wr_status;
    logic               wr_cur_x;
    logic               wr_cur_y;
    logic [31:0]        rd_dat;
    logic [COORD_W-1:0] cur_x, cur_y, nx, ny, wr_coord;
    logic [15:0]        cur_vel;
    logic [2:0]         cur_ctrl;
    logic               unused;

    assign off       = bus.address - BASE_ADDR;
    assign widx      = off[31:2];
    assign wr_en     = !bus.memWr && (widx < 30'(4*N_SPRITES + 1));
    assign wr_status = wr_en && (widx == 30'(4*N_SPRITES));
    assign wr_cur_x  = wr_en && (widx == 30'({idx, 2'b00}));
    assign wr_cur_y  = wr_en && (widx == 30'({idx, 2'b01}));
    assign wr_coord  = bus.datoIn[COORD_W-1:0];
    assign unused    = ^{off[1:0], bus.datoIn[31:16]};

    // One step on a single axis, with single-shot wrap or saturation.
    function automatic logic [COORD_W-1:0] step_axis(
        input logic [COORD_W-1:0]     p,
        input logic [7:0]             d,
        input logic                   mv,
        input logic                   clamp,
        input logic signed [SIGW-1:0] lim
    );
        logic signed [SIGW-1:0] n;
        n = $signed({2'b00, p});
        if (mv)
            n = n + $signed({{(SIGW-8){d[7]}}, d});
        if (clamp) begin
            if (n[SIGW-1])     n = '0;
            else if (n >= lim) n = lim - SIGW'(1);
        end else begin
            if (n[SIGW-1])     n = n + lim;
            else if (n >= lim) n = n - lim;
        end
        return n[COORD_W-1:0];
    endfunction

    always_comb begin
        rd_dat   = '0;
        cur_x    = '0;
        cur_y    = '0;
        cur_vel  = '0;
        cur_ctrl = '0;
        if (widx == 30'(4*N_SPRITES))
            rd_dat = {14'd0, state == UPDATE, overrun, frame_count};
        for (int i = 0; i < N_SPRITES; i++) begin
            if (widx == 30'(4*i))     rd_dat = 32'(sh_x[i]);
            if (widx == 30'(4*i + 1)) rd_dat = 32'(sh_y[i]);
            if (widx == 30'(4*i + 2)) rd_dat = 32'(vel[i]);
            if (widx == 30'(4*i + 3)) rd_dat = 32'(ctrl[i]);
            if (idx == IW'(i)) begin
                cur_x    = sh_x[i];
                cur_y    = sh_y[i];
                cur_vel  = vel[i];
                cur_ctrl = ctrl[i];
            end
        end
        nx = step_axis(cur_x, cur_vel[7:0],  cur_ctrl[0], cur_ctrl[1], LIM_X);
        ny = step_axis(cur_y, cur_vel[15:8], cur_ctrl[0], cur_ctrl[1], LIM_Y);
    end

    assign bus.datoOut = rd_dat;

    always_ff @(negedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            idx         <= '0;
            frame_count <= '0;
            overrun     <= 1'b0;
            spriteX     <= '0;
            spriteY     <= '0;
            spriteEn    <= '0;
            for (int i = 0; i < N_SPRITES; i++) begin
                sh_x[i] <= '0;
                sh_y[i] <= '0;
                vel[i]  <= '0;
                ctrl[i] <= '0;
            end
        end else begin
            // Clear first so a coincident late tick still leaves overrun set.
            if (wr_status)
                overrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (frameTick) begin
                        state       <= UPDATE;
                        idx         <= '0;
                        frame_count <= frame_count + 16'd1;
                    end
                end
                UPDATE: begin
                    if (frameTick)
                        overrun <= 1'b1;
                    for (int i = 0; i < N_SPRITES; i++) begin
                        if (idx == IW'(i)) begin
                            sh_x[i] <= nx;
                            sh_y[i] <= ny;
                            spriteX[i*COORD_W +: COORD_W] <= wr_cur_x ? wr_coord : nx;
                            spriteY[i*COORD_W +: COORD_W] <= wr_cur_y ? wr_coord : ny;
                            spriteEn[i] <= cur_ctrl[2];
                        end
                    end
                    if (idx == IW'(N_SPRITES - 1)) begin
                        state <= IDLE;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            // CPU writes come last so they override the engine on a collision.
            if (wr_en) begin
                for (int i = 0; i < N_SPRITES; i++) begin
                    if (widx == 30'(4*i))     sh_x[i] <= wr_coord;
                    if (widx == 30'(4*i + 1)) sh_y[i] <= wr_coord;
                    if (widx == 30'(4*i + 2)) vel[i]  <= bus.datoIn[15:0];
                    if (widx == 30'(4*i + 3)) ctrl[i] <= bus.datoIn[2:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_sprite_position_regfile.sv
// Directed, table-driven bench for sprite_position_regfile (default parameters).
// Inputs change just after the rising edge; the DUT acts on the falling edge.
module tb_sprite_position_regfile;
    localparam int N  = 5;
    localparam int CW = 10;
    localparam int STATUS_W = 4*N;

    logic          clk = 1'b0;
    logic          reset;
    logic          frameTick;
    logic [N*CW-1:0] spriteX, spriteY;
    logic [N-1:0]  spriteEn;

    sprite_position_regfile_if bus ();

    sprite_position_regfile dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .frameTick (frameTick),
        .spriteX   (spriteX),
        .spriteY   (spriteY),
        .spriteEn  (spriteEn)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          word;
        logic [31:0] wdat;
        logic [31:0] exp;
    } reg_vec_t;

    typedef struct {
        logic [31:0] x, y, vel, ctrl;
        logic [31:0] ex, ey;
        logic        en;
    } mv_vec_t;

    reg_vec_t rv [8];
    mv_vec_t  mv [N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int w, input logic [31:0] d);
        bus.memWr   = 1'b0;
        bus.address = 32'(w * 4);
        bus.datoIn  = d;
        step();
        bus.memWr   = 1'b1;
    endtask

    task automatic rd(input int w, output logic [31:0] d);
        bus.address = 32'(w * 4);
        #1;
        d = bus.datoOut;
    endtask

    function automatic logic [31:0] gx(input int i);
        return 32'(spriteX[i*CW +: CW]);
    endfunction

    function automatic logic [31:0] gy(input int i);
        return 32'(spriteY[i*CW +: CW]);
    endfunction

    task automatic check_all_zero(input string tag);
        logic [31:0] d;
        for (int w = 0; w <= STATUS_W; w++) begin
            rd(w, d);
            check($sformatf("%s word%0d", tag, w), d, 32'h0);
        end
        check({tag, " spriteX"},  32'(spriteX != '0),  32'h0);
        check({tag, " spriteY"},  32'(spriteY != '0),  32'h0);
        check({tag, " spriteEn"}, 32'(spriteEn), 32'h0);
    endtask

    initial begin
        logic [31:0] d;

        rv[0] = '{0,  32'd100,       32'd100};
        rv[1] = '{1,  32'hFFFF_FFFF, 32'h0000_03FF};
        rv[2] = '{2,  32'hDEAD_FB05, 32'h0000_FB05};
        rv[3] = '{3,  32'h0000_00FF, 32'h0000_0007};
        rv[4] = '{20, 32'hFFFF_FFFF, 32'h0000_0000};
        rv[5] = '{21, 32'h0000_1234, 32'h0000_0000};
        rv[6] = '{7,  32'h0000_0005, 32'h0000_0005};
        rv[7] = '{6,  32'h0000_0000, 32'h0000_0000};

        mv[0] = '{32'd100, 32'd0,   32'h0505, 32'b110, 32'd100, 32'd0,   1'b1};
        mv[1] = '{32'd638, 32'd10,  32'h0005, 32'b101, 32'd3,   32'd10,  1'b1};
        mv[2] = '{32'd20,  32'd478, 32'h0A00, 32'b111, 32'd20,  32'd479, 1'b1};
        mv[3] = '{32'd2,   32'd1,   32'hFDFB, 32'b001, 32'd637, 32'd478, 1'b0};
        mv[4] = '{32'd600, 32'd3,   32'hF67F, 32'b011, 32'd639, 32'd0,   1'b0};

        reset       = 1'b0;
        frameTick   = 1'b0;
        bus.memWr   = 1'b1;
        bus.address = '0;
        bus.datoIn  = '0;
        repeat (3) step();
        reset = 1'b1;
        step();
        check_all_zero("reset");

        // Register write/readback table.
        foreach (rv[k]) begin
            wr(rv[k].word, rv[k].wdat);
            rd(rv[k].word, d);
            check($sformatf("regrw word%0d", rv[k].word), d, rv[k].exp);
        end
        check("x0 display before tick", gx(0), 32'h0);
        wr(32'h0400_0000, 32'h55);
        rd(0, d);
        check("far write ignored", d, 32'd100);

        // Motion table: one frame moves every sprite.
        foreach (mv[i]) begin
            wr(4*i,     mv[i].x);
            wr(4*i + 1, mv[i].y);
            wr(4*i + 2, mv[i].vel);
            wr(4*i + 3, mv[i].ctrl);
        end
        frameTick = 1'b1;
        step();                       // edge T
        frameTick = 1'b0;
        rd(STATUS_W, d);
        check("status busy", d, 32'h0002_0001);
        step();                       // edge T+1
        check("x1 before T+2", gx(1), 32'h0);
        step();                       // edge T+2
        check("x1 at T+2", gx(1), 32'd3);
        repeat (3) step();            // edge T+5
        rd(STATUS_W, d);
        check("status idle", d, 32'h0000_0001);
        foreach (mv[i]) begin
            check($sformatf("disp x%0d", i), gx(i), mv[i].ex);
            check($sformatf("disp y%0d", i), gy(i), mv[i].ey);
            check($sformatf("en%0d", i), 32'(spriteEn[i]), 32'(mv[i].en));
            rd(4*i, d);
            check($sformatf("shadow x%0d", i), d, mv[i].ex);
            rd(4*i + 1, d);
            check($sformatf("shadow y%0d", i), d, mv[i].ey);
        end

        // CPU write to X3 on the edge that processes sprite 3.
        wr(12, 32'd10);
        wr(13, 32'd50);
        wr(14, 32'h0104);
        wr(15, 32'b101);
        frameTick = 1'b1;
        step();                       // edge T
        frameTick = 1'b0;
        repeat (3) step();            // edges T+1..T+3
        wr(12, 32'd200);              // edge T+4
        step();                       // edge T+5
        check("collide disp x3", gx(3), 32'd200);
        check("collide disp y3", gy(3), 32'd51);
        rd(12, d);
        check("collide shadow x3", d, 32'd200);
        rd(13, d);
        check("collide shadow y3", d, 32'd51);
        rd(STATUS_W, d);
        check("status frame2", d, 32'h0000_0002);

        // Ticks two cycles apart.
        frameTick = 1'b1;
        step();                       // edge T
        frameTick = 1'b0;
        step();
        frameTick = 1'b1;
        step();                       // edge T+2
        frameTick = 1'b0;
        repeat (4) step();
        rd(STATUS_W, d);
        check("overrun set", d, 32'h0001_0003);
        wr(STATUS_W, 32'h0);
        rd(STATUS_W, d);
        check("overrun cleared", d, 32'h0000_0003);

        // Reset in the middle of an update.
        frameTick = 1'b1;
        step();                       // edge T
        frameTick = 1'b0;
        step();
        step();                       // edge T+2
        reset = 1'b0;
        step();                       // edge T+3
        reset = 1'b1;
        check_all_zero("midreset");
        repeat (4) step();
        rd(STATUS_W, d);
        check("status after midreset", d, 32'h0);
        check("x1 after midreset", gx(1), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
